// File: rtl/seg_scan_if.sv
// Seven-segment scan bus between a display driver (master) and the scan receiver (slave).
// Revision: 1.0
`default_nettype none

interface seg_scan_if;
  logic [2:0]  seg_an;
  logic [3:0]  seg_data;
  logic        clr;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic [31:0] frame;
  logic        frame_valid;
  logic        frame_changed;

  modport master (
    output seg_an, seg_data, clr,
    input  digits, digit_valid, frame, frame_valid, frame_changed
  );

  modport slave (
    input  seg_an, seg_data, clr,
    output digits, digit_valid, frame, frame_valid, frame_changed
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_rx.sv
// seg_scan_rx: debounces the scanned digit index/nibble and rebuilds the 8-digit display word.
// Revision: 1.0
`default_nettype none

module seg_scan_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

  logic [6:0]  r_s;
  logic [7:0]  r_cnt;
  logic [31:0] r_digits;
  logic [7:0]  r_digit_valid;
  logic [31:0] r_frame;
  logic        r_frame_valid;
  logic        r_frame_changed;
  logic        r_first;

  logic [6:0]  w_raw;
  logic        w_match;
  logic [7:0]  w_cnt_next;
  logic        w_commit;
  logic [31:0] w_digits_upd;
  logic [7:0]  w_valid_upd;
  logic        w_complete;

  always_comb begin
    w_raw        = {bus.seg_an, bus.seg_data};
    w_match      = (w_raw == r_s);
    w_cnt_next   = 8'd0;
    if (w_match)
      w_cnt_next = (r_cnt >= c_STABLE) ? c_STABLE : r_cnt + 8'd1;
    // Commit exactly once per stable period: only on the step into saturation.
    w_commit     = w_match && (r_cnt == c_STABLE - 8'd1);
    w_digits_upd = r_digits;
    w_digits_upd[4*bus.seg_an +: 4] = bus.seg_data;
    w_valid_upd  = r_digit_valid | (8'd1 << bus.seg_an);
    w_complete   = w_commit && (&w_valid_upd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s             <= 7'h00;
      r_cnt           <= 8'd0;
      r_digits        <= 32'd0;
      r_digit_valid   <= 8'd0;
      r_frame         <= 32'd0;
      r_frame_valid   <= 1'b0;
      r_frame_changed <= 1'b0;
      r_first         <= 1'b1;
    end else if (bus.clr) begin
      r_s             <= 7'h00;
      r_cnt           <= 8'd0;
      r_digits        <= 32'd0;
      r_digit_valid   <= 8'd0;
      r_frame         <= 32'd0;
      r_frame_valid   <= 1'b0;
      r_frame_changed <= 1'b0;
      r_first         <= 1'b1;
    end else begin
      r_s             <= w_raw;
      r_cnt           <= w_cnt_next;
      r_frame_valid   <= w_complete;
      r_frame_changed <= w_complete && (r_first || (w_digits_upd != r_frame));
      if (w_commit) begin
        r_digits      <= w_digits_upd;
        r_digit_valid <= w_complete ? 8'd0 : w_valid_upd;
      end
      if (w_complete) begin
        r_frame <= w_digits_upd;
        r_first <= 1'b0;
      end
    end
  end

  assign bus.digits        = r_digits;
  assign bus.digit_valid   = r_digit_valid;
  assign bus.frame         = r_frame;
  assign bus.frame_valid   = r_frame_valid;
  assign bus.frame_changed = r_frame_changed;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_rx.sv
// tb_seg_scan_rx: directed self-checking bench for seg_scan_rx.
// Revision: 1.0
`default_nettype none

module tb_seg_scan_rx;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   fv_cnt;
  int   fv_base;
  logic [31:0] last_frame;
  logic        last_changed;

  seg_scan_if bus ();

  seg_scan_rx #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse capture: frame_valid is high across exactly one falling edge per pulse.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_cnt       = fv_cnt + 1;
      last_frame   = bus.frame;
      last_changed = bus.frame_changed;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [2:0] an, input logic [3:0] d, input int n);
    bus.seg_an   = an;
    bus.seg_data = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [31:0] word);
    for (int i = 0; i < 8; i++) hold(3'(i), word[4*i +: 4], 6);
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; fv_cnt = 0;
    last_frame = 32'd0; last_changed = 1'b0;
    rst = 1'b0;
    bus.seg_an = 3'd0; bus.seg_data = 4'd0; bus.clr = 1'b0;

    #12;
    check("rst_digits", bus.digits, 32'd0);
    check("rst_valid", {24'd0, bus.digit_valid}, 32'd0);
    check("rst_frame", bus.frame, 32'd0);
    check("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
    check("rst_fc", {31'd0, bus.frame_changed}, 32'd0);
    #10 rst = 1'b1;

    // Ordered scan
    fv_base = fv_cnt;
    scan(32'h76543210);
    check("scan1_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    check("scan1_frame", last_frame, 32'h76543210);
    check("scan1_changed", {31'd0, last_changed}, 32'd1);
    check("scan1_valid_after", {24'd0, bus.digit_valid}, 32'd0);
    check("scan1_digits_kept", bus.digits, 32'h76543210);

    // Identical repeat, then digit 3 changed
    fv_base = fv_cnt;
    scan(32'h76543210);
    check("scan2_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    check("scan2_changed", {31'd0, last_changed}, 32'd0);
    fv_base = fv_cnt;
    scan(32'h76549210);
    check("scan3_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    check("scan3_frame", last_frame, 32'h76549210);
    check("scan3_changed", {31'd0, last_changed}, 32'd1);

    // Glitch rejection: 4 samples is too short, 5 commits
    hold(3'd2, 4'd5, 4);
    check("glitch4_valid", {24'd0, bus.digit_valid}, 32'd0);
    hold(3'd3, 4'd0, 1);
    check("glitch_switch_valid", {24'd0, bus.digit_valid}, 32'd0);
    hold(3'd2, 4'd5, 4);
    check("hold_edge3_valid", {24'd0, bus.digit_valid}, 32'd0);
    hold(3'd2, 4'd5, 1);
    check("hold_edge4_valid", {24'd0, bus.digit_valid}, 32'h04);
    check("hold_edge4_nibble", {28'd0, bus.digits[11:8]}, 32'd5);

    // Out-of-order scan with duplicate index 1
    bus.seg_an = 3'd7; bus.seg_data = 4'd7;
    pulse_clr();
    check("clr_valid", {24'd0, bus.digit_valid}, 32'd0);
    check("clr_frame", bus.frame, 32'd0);
    fv_base = fv_cnt;
    hold(3'd7, 4'd7, 6);
    hold(3'd1, 4'd1, 6);
    hold(3'd1, 4'd8, 6);
    hold(3'd0, 4'd0, 6);
    hold(3'd6, 4'd6, 6);
    hold(3'd5, 4'd5, 6);
    hold(3'd4, 4'd4, 6);
    hold(3'd3, 4'd3, 6);
    check("ooo_no_early_fv", 32'(fv_cnt - fv_base), 32'd0);
    check("ooo_valid_before_2", {24'd0, bus.digit_valid}, 32'hFB);
    hold(3'd2, 4'd2, 6);
    check("ooo_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    check("ooo_frame", last_frame, 32'h76543280);

    // Abort by clr, then all-zero frame must still report a change
    fv_base = fv_cnt;
    for (int i = 0; i < 5; i++) hold(3'(i), 4'(i + 1), 6);
    check("abort_valid_partial", {24'd0, bus.digit_valid}, 32'h1F);
    pulse_clr();
    check("abort_clr_digits", bus.digits, 32'd0);
    check("abort_clr_valid", {24'd0, bus.digit_valid}, 32'd0);
    check("abort_clr_frame", bus.frame, 32'd0);
    check("abort_clr_no_fv", 32'(fv_cnt - fv_base), 32'd0);
    scan(32'h00000000);
    check("zero_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    check("zero_first_changed", {31'd0, last_changed}, 32'd1);

    // Abort by asynchronous reset mid-cycle
    scan(32'h13572468);
    fv_base = fv_cnt;
    for (int i = 0; i < 5; i++) hold(3'(i), 4'(i + 2), 6);
    #2 rst = 1'b0;
    #1;
    check("arst_digits", bus.digits, 32'd0);
    check("arst_valid", {24'd0, bus.digit_valid}, 32'd0);
    check("arst_frame", bus.frame, 32'd0);
    #10 rst = 1'b1;
    check("arst_no_fv", 32'(fv_cnt - fv_base), 32'd0);
    scan(32'h76543210);
    check("arst_scan_fv", 32'(fv_cnt - fv_base), 32'd1);
    check("arst_scan_changed", {31'd0, last_changed}, 32'd1);
    check("arst_scan_frame", last_frame, 32'h76543210);

    // Long hold: a single commit, no frame
    fv_base = fv_cnt;
    hold(3'd0, 4'd1, 50);
    check("long_valid", {24'd0, bus.digit_valid}, 32'h01);
    check("long_nibble", {28'd0, bus.digits[3:0]}, 32'd1);
    check("long_no_fv", 32'(fv_cnt - fv_base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_rx.md
# seg_scan_rx

Receive side of the multiplexed seven-segment scan bus driven by the timer/display blocks. It samples the scanned digit index and BCD nibble, accepts each digit only after it has been stable for a programmable number of cycles, and rebuilds the full 8-digit display word. It reports frame completion and value changes, which makes it usable both as a bench/on-chip monitor and as a loop-back checker for the display driver.

## Interface
- STABLE_CYCLES, default 4: equal consecutive samples required before a digit is committed; legal range 2..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately.
- seg_an  in  3  scanned digit index, 0..7.
- seg_data  in  4  nibble for the digit at seg_an.
- clr  in  1  synchronous clear; same effect as reset, applied on the next edge.
- digits  out  32  working digit registers; digit i is bits [4i+3:4i].
- digit_valid  out  8  bit i set once digit i has been committed in the current frame.
- frame  out  32  last completed frame, the snapshot of digits at completion.
- frame_valid  out  1  one-cycle pulse on frame completion.
- frame_changed  out  1  one-cycle pulse, coincident with frame_valid, when the new frame differs from the previous frame.

## Operation
- Sample register: s = {seg_an, seg_data}, loaded every edge. Reset value 7'h00.
- Stability counter cnt, 8 bits:
  - If the raw input equals s, cnt <= min(cnt+1, STABLE_CYCLES).
  - Otherwise cnt <= 0.
- Commit: when the raw input equals s and cnt == STABLE_CYCLES-1, then on that edge:
  - digits[4*seg_an +: 4] <= seg_data;
  - digit_valid[seg_an] <= 1.
- Exactly one commit per stable period. A saturated counter does not re-commit.
- Re-commit of an index already valid in this frame overwrites the nibble; digit_valid is unchanged.
- Frame completion: a commit that makes digit_valid all-ones (including the committed bit) causes, on the same edge:
  - frame <= the updated digits;
  - frame_valid <= 1;
  - digit_valid <= 0.
  - digits is retained.
- frame_changed <= 1 on that edge if the updated digits differ from the current frame.
  - The first frame after reset or clr always sets frame_changed, because a first-frame flag is held.
- Glitches: any input change shorter than STABLE_CYCLES+1 samples produces no commit.
- clr or reset: every output and every internal register goes to 0 (cnt=0, s=0, first-frame flag=1).
- clr has priority over a simultaneous commit.
- Reset mid-frame discards the partial frame. No pulse is generated.

## Timing
- Reset values: digits=0, digit_valid=0, frame=0, frame_valid=0, frame_changed=0.
- Latency, with input stable before edge 0 and differing from s:
  - edge 0 captures s, cnt=0;
  - edge k gives cnt=k;
  - the commit is visible after edge STABLE_CYCLES.
  - The input must therefore be held for STABLE_CYCLES+1 edges (default 5).
- frame_valid and frame_changed are registered. They are high for exactly the one cycle following the completing commit edge.
- Input equal to reset s (an=0, data=0) right after reset release counts from cnt=0 immediately. It commits digit 0 = 0 after STABLE_CYCLES edges.
- Index order is irrelevant. Completion requires all 8 indices regardless of scan order or repeats.
- Back-to-back frames: the first commit after completion starts the new frame on the next eligible edge, with no dead cycle.
- Inputs are assumed synchronous to clk; no synchronizer is included.

## Test plan
- Reset then ordered scan: for i=0..7 hold an=i, data=i for 6 cycles each -> one frame_valid pulse with frame=32'h76543210 and frame_changed=1; digit_valid=0 after the pulse.
- Repeat the identical scan -> frame_valid=1, frame_changed=0. Then repeat with digit 3 = 9 -> frame=32'h76549210, frame_changed=1.
- Glitch rejection, STABLE_CYCLES=4: hold an=2, data=5 for 4 cycles only, then an=3 -> digit 2 not committed (digit_valid[2]=0). Hold for 5 cycles -> committed exactly after edge 4.
- Out-of-order scan with duplicates (7,1,1,0,6,5,4,3,2), second "1" carrying data=8 -> single frame_valid after index 2; frame nibble 1 = 8.
- Abort mid-frame: commit digits 0..4, then pulse clr (and separately drop rst asynchronously mid-cycle) -> all outputs 0 immediately for rst / next edge for clr; no frame_valid; a following full scan yields frame_changed=1.
- Long hold: keep an=0, data=1 for 50 cycles -> exactly one commit; cnt saturates; no frame_valid.
